// File: rtl/utm_pkg.sv
// ---------------------------------------------------------------------------
// utm_pkg
// Purpose : Shared definitions for the UTM tape controller and the
//           transition-function wrapper: field widths, head-move direction
//           encoding, default halt state and the controller FSM encoding.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package utm_pkg;

  localparam int SYM_W   = 3;
  localparam int STATE_W = 3;

  // Head move direction as delivered by the transition function
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [STATE_W-1:0] HALT_STATE_DEFAULT = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } utm_fsm_t;

endpackage

// File: rtl/utm_tape_ram.sv
// ---------------------------------------------------------------------------
// utm_tape_ram
// Purpose : Tape storage, TAPE_LEN cells of SYM_W bits. One synchronous write
//           port (the caller muxes host load vs. transition commit) and two
//           combinational read ports (head cell, host readback cell).
//           Contents are not reset.
// Ports   : clk               clock
//           we/waddr/wdata    write port, applied on the rising edge
//           raddr_a/rdata_a   combinational read port A (head)
//           raddr_b/rdata_b   combinational read port B (readback)
// ---------------------------------------------------------------------------
module utm_tape_ram
  import utm_pkg::*;
#(
  parameter int TAPE_LEN = 16,
  parameter int AW       = $clog2(TAPE_LEN)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [SYM_W-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [SYM_W-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [SYM_W-1:0] rdata_b
);

  logic [SYM_W-1:0] cells [TAPE_LEN];

  // TAPE_LEN is a power of two, so every AW-bit address is a valid cell
  always_ff @(posedge clk) begin
    if (we) begin
      cells[waddr] <= wdata;
    end
  end

  assign rdata_a = cells[raddr_a];
  assign rdata_b = cells[raddr_b];

endmodule

// File: rtl/utm_tape_controller.sv
// ---------------------------------------------------------------------------
// utm_tape_controller
// Purpose : Sequential driver around a combinational UTM transition function.
//           Owns the tape, the head and the current state. Each RUN advance
//           cycle presents {cur_state, tape[head]} and commits the returned
//           symbol / next state / head move. A run ends on the halt state,
//           on a move off either tape edge, or on the step limit.
// Ports   : clk, rst_n                 clock, synchronous active-low reset
//           start, single_step,        run control
//           step_req, init_state,
//           init_head
//           load_en, load_addr,        host tape load (outside RUN) and
//           load_sym, rd_sym           combinational readback
//           tf_state, tf_sym           to the transition function
//           tf_new_state, tf_new_sym,  from the transition function
//           tf_dir
//           cur_state, head,           machine status
//           step_count, running,
//           halted, fault
// ---------------------------------------------------------------------------
module utm_tape_controller
  import utm_pkg::*;
#(
  parameter int                 TAPE_LEN   = 16,
  parameter logic [STATE_W-1:0] HALT_STATE = HALT_STATE_DEFAULT,
  parameter int                 MAX_STEPS  = 65535,
  localparam int                AW         = $clog2(TAPE_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               single_step,
  input  logic               step_req,
  input  logic [STATE_W-1:0] init_state,
  input  logic [AW-1:0]      init_head,
  input  logic               load_en,
  input  logic [AW-1:0]      load_addr,
  input  logic [SYM_W-1:0]   load_sym,
  output logic [SYM_W-1:0]   rd_sym,
  output logic [STATE_W-1:0] tf_state,
  output logic [SYM_W-1:0]   tf_sym,
  input  logic [STATE_W-1:0] tf_new_state,
  input  logic [SYM_W-1:0]   tf_new_sym,
  input  logic               tf_dir,
  output logic [STATE_W-1:0] cur_state,
  output logic [AW-1:0]      head,
  output logic [15:0]        step_count,
  output logic               running,
  output logic               halted,
  output logic               fault
);

  utm_fsm_t           state_reg, state_next;
  logic [STATE_W-1:0] cur_state_reg, cur_state_next;
  logic [AW-1:0]      head_reg, head_next;
  logic [15:0]        step_count_reg, step_count_next;
  logic               running_reg, halted_reg, fault_reg;

  logic               tape_we_next;
  logic [AW-1:0]      tape_waddr_next;
  logic [SYM_W-1:0]   tape_wdata_next;
  logic               tape_we_gated;

  logic               advance;
  logic               off_edge;

  // Tape write is suppressed while reset is held so an aborted run leaves
  // exactly the cells it had already committed.
  assign tape_we_gated = tape_we_next & rst_n;

  utm_tape_ram #(
    .TAPE_LEN (TAPE_LEN),
    .AW       (AW)
  ) u_tape (
    .clk     (clk),
    .we      (tape_we_gated),
    .waddr   (tape_waddr_next),
    .wdata   (tape_wdata_next),
    .raddr_a (head_reg),
    .rdata_a (tf_sym),
    .raddr_b (load_addr),
    .rdata_b (rd_sym)
  );

  assign advance  = ~single_step | step_req;
  // The move is checked before it is applied, so head never wraps
  assign off_edge = (tf_dir == DIR_LEFT) ? (head_reg == '0)
                                         : (head_reg == AW'(TAPE_LEN - 1));

  always_comb begin
    state_next      = state_reg;
    cur_state_next  = cur_state_reg;
    head_next       = head_reg;
    step_count_next = step_count_reg;
    tape_we_next    = 1'b0;
    tape_waddr_next = load_addr;
    tape_wdata_next = load_sym;

    case (state_reg)
      RUN: begin
        if (advance) begin
          if (cur_state_reg == HALT_STATE) begin
            state_next = DONE;
          end else if (step_count_reg == 16'(MAX_STEPS)) begin
            state_next = FAULT;
          end else begin
            // Commit the transition; an edge move still writes and counts
            tape_we_next    = 1'b1;
            tape_waddr_next = head_reg;
            tape_wdata_next = tf_new_sym;
            cur_state_next  = tf_new_state;
            step_count_next = step_count_reg + 16'd1;
            if (off_edge) begin
              state_next = FAULT;
            end else if (tf_dir == DIR_RIGHT) begin
              head_next = head_reg + AW'(1);
            end else begin
              head_next = head_reg - AW'(1);
            end
          end
        end
      end
      default: begin
        // IDLE, DONE, FAULT: a load wins over a simultaneous start
        if (load_en) begin
          tape_we_next = 1'b1;
        end else if (start) begin
          cur_state_next  = init_state;
          head_next       = init_head;
          step_count_next = 16'd0;
          state_next      = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cur_state_reg  <= '0;
      head_reg       <= '0;
      step_count_reg <= '0;
      running_reg    <= 1'b0;
      halted_reg     <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_state_reg  <= cur_state_next;
      head_reg       <= head_next;
      step_count_reg <= step_count_next;
      // Registered decodes, aligned with state_reg
      running_reg    <= (state_next == RUN);
      halted_reg     <= (state_next == DONE);
      fault_reg      <= (state_next == FAULT);
    end
  end

  assign tf_state   = cur_state_reg;
  assign cur_state  = cur_state_reg;
  assign head       = head_reg;
  assign step_count = step_count_reg;
  assign running    = running_reg;
  assign halted     = halted_reg;
  assign fault      = fault_reg;

endmodule

// File: tb/tb_utm_tape_controller.sv
// ---------------------------------------------------------------------------
// tb_utm_tape_controller
// Purpose : Self-checking bench for utm_tape_controller. The bench plays the
//           transition function (several rule sets, including a random
//           table) and keeps a behavioural model of tape/head/state that is
//           stepped directly from the machine's rules.
// ---------------------------------------------------------------------------
module tb_utm_tape_controller;

  localparam int TL    = 16;
  localparam int MAXS  = 5;
  localparam int HALT  = 7;

  localparam int M_INC   = 0;  // (s,x) -> (s+1, x+1, right)
  localparam int M_LEFT5 = 1;  // (s,x) -> (1, 5, left)
  localparam int M_PING  = 2;  // alternate right/left between states 0 and 1
  localparam int M_RAND  = 3;  // random table

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, single_step, step_req;
  logic [2:0] init_state;
  logic [3:0] init_head;
  logic       load_en;
  logic [3:0] load_addr;
  logic [2:0] load_sym;
  logic [2:0] rd_sym, tf_state, tf_sym;
  logic [2:0] tf_new_state, tf_new_sym;
  logic       tf_dir;
  logic [2:0] cur_state;
  logic [3:0] head;
  logic [15:0] step_count;
  logic       running, halted, fault;

  int         tf_mode;
  logic [6:0] tf_tab [64];
  logic [6:0] tf_out;
  logic [2:0] m_tape [TL];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  utm_tape_controller #(
    .TAPE_LEN   (TL),
    .HALT_STATE (3'd7),
    .MAX_STEPS  (MAXS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .single_step  (single_step),
    .step_req     (step_req),
    .init_state   (init_state),
    .init_head    (init_head),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_sym     (load_sym),
    .rd_sym       (rd_sym),
    .tf_state     (tf_state),
    .tf_sym       (tf_sym),
    .tf_new_state (tf_new_state),
    .tf_new_sym   (tf_new_sym),
    .tf_dir       (tf_dir),
    .cur_state    (cur_state),
    .head         (head),
    .step_count   (step_count),
    .running      (running),
    .halted       (halted),
    .fault        (fault)
  );

  // Returns {next_state, new_sym, dir}
  function automatic logic [6:0] tf_fn(input int mode, input logic [2:0] s,
                                       input logic [2:0] x, input logic [6:0] tab);
    logic [6:0] r;
    case (mode)
      M_INC:   r = {s + 3'd1, x + 3'd1, 1'b1};
      M_LEFT5: r = {3'd1, 3'd5, 1'b0};
      M_PING:  r = {(s == 3'd0) ? 3'd1 : 3'd0, x, (s == 3'd0)};
      default: r = tab;
    endcase
    return r;
  endfunction

  always_comb begin
    tf_out = tf_fn(tf_mode, tf_state, tf_sym, tf_tab[{tf_state, tf_sym}]);
  end
  assign tf_new_state = tf_out[6:4];
  assign tf_new_sym   = tf_out[3:1];
  assign tf_dir       = tf_out[0];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_cell(input int a, input logic [2:0] v);
    load_en   = 1'b1;
    load_addr = 4'(a);
    load_sym  = v;
    tick;
    load_en   = 1'b0;
    m_tape[a] = v;
  endtask

  task automatic check_tape(input string tag);
    for (int a = 0; a < TL; a++) begin
      load_addr = 4'(a);
      #1;
      check($sformatf("%s tape[%0d]", tag, a), 32'(rd_sym), 32'(m_tape[a]));
    end
  endtask

  // Model the whole run from the machine rules, then drive it on the DUT
  // in free-running mode and compare the end state and run length.
  task automatic run_and_check(input string tag, input logic [2:0] s0,
                               input logic [3:0] h0, input bit inject);
    logic [2:0] s;
    logic [6:0] r;
    int h, n, cyc, cyc_exp;
    bit m_halt, m_flt;
    s = s0; h = int'(h0); n = 0; m_halt = 0; m_flt = 0; cyc_exp = 0;
    while (1) begin
      if (int'(s) == HALT) begin m_halt = 1; cyc_exp = n + 1; break; end
      if (n == MAXS)       begin m_flt = 1;  cyc_exp = n + 1; break; end
      r = tf_fn(tf_mode, s, m_tape[h], tf_tab[{s, m_tape[h]}]);
      m_tape[h] = r[3:1];
      s = r[6:4];
      n++;
      if ((h == 0 && !r[0]) || (h == TL - 1 && r[0])) begin
        m_flt = 1; cyc_exp = n; break;
      end
      h = r[0] ? h + 1 : h - 1;
    end

    init_state = s0;
    init_head  = h0;
    start      = 1'b1;
    tick;
    start      = 1'b0;
    check({tag, " running"}, 32'(running), 32'd1);
    cyc = 0;
    if (inject) begin
      // RUN must ignore both a load and a repeated start
      load_en = 1'b1; load_addr = 4'd4; load_sym = 3'd2; start = 1'b1;
      tick;
      load_en = 1'b0; start = 1'b0;
      cyc = 1;
    end
    while (running && cyc < 100) begin
      tick;
      cyc++;
    end
    check({tag, " cycles"},     32'(cyc),        32'(cyc_exp));
    check({tag, " running"},    32'(running),    32'd0);
    check({tag, " cur_state"},  32'(cur_state),  32'(s));
    check({tag, " head"},       32'(head),       32'(h));
    check({tag, " step_count"}, 32'(step_count), 32'(n));
    check({tag, " halted"},     32'(halted),     32'(m_halt));
    check({tag, " fault"},      32'(fault),      32'(m_flt));
    $display("run %s: init_state=%0d init_head=%0d steps=%0d halted=%0d fault=%0d",
             tag, s0, h0, step_count, halted, fault);
  endtask

  initial begin
    logic [2:0] es;
    logic [3:0] eh;
    int en;

    rst_n = 1'b0; start = 1'b0; single_step = 1'b0; step_req = 1'b0;
    init_state = '0; init_head = '0; load_en = 1'b0; load_addr = '0; load_sym = '0;
    tf_mode = M_INC;
    for (int i = 0; i < 64; i++) tf_tab[i] = 7'd0;
    tick; tick;
    rst_n = 1'b1;
    check("rst cur_state",  32'(cur_state),  32'd0);
    check("rst head",       32'(head),       32'd0);
    check("rst step_count", 32'(step_count), 32'd0);
    check("rst running",    32'(running),    32'd0);
    check("rst halted",     32'(halted),     32'd0);
    check("rst fault",      32'(fault),      32'd0);

    // Halt path
    for (int a = 0; a < TL; a++) load_cell(a, 3'd0);
    tf_mode = M_INC;
    run_and_check("halt", 3'd3, 4'd2, 0);
    check("halt step_count lit", 32'(step_count), 32'd4);
    check("halt head lit",       32'(head),       32'd6);
    check_tape("halt");

    // Left edge
    tf_mode = M_LEFT5;
    load_cell(0, 3'd3);
    run_and_check("ledge", 3'd0, 4'd0, 0);
    load_addr = 4'd0; #1;
    check("ledge tape0 lit", 32'(rd_sym), 32'd5);

    // Right edge
    tf_mode = M_INC;
    run_and_check("redge", 3'd2, 4'd14, 0);
    check_tape("redge");

    // Single-step, then reset in the middle of the run
    for (int a = 0; a < TL; a++) load_cell(a, 3'd0);
    tf_mode = M_INC;
    single_step = 1'b1;
    init_state = 3'd0; init_head = 4'd4;
    start = 1'b1; tick; start = 1'b0;
    es = 3'd0; eh = 4'd4; en = 0;
    for (int c = 0; c < 10; c++) begin
      step_req = (c == 2 || c == 5 || c == 8);
      tick;
      if (step_req) begin
        m_tape[eh] = m_tape[eh] + 3'd1;
        es = es + 3'd1; eh = eh + 4'd1; en++;
      end
      step_req = 1'b0;
      check($sformatf("sstep c%0d cur_state", c), 32'(cur_state), 32'(es));
      check($sformatf("sstep c%0d head", c),      32'(head),      32'(eh));
      $display("sstep cycle %0d: cur_state=%0d head=%0d step_count=%0d",
               c, cur_state, head, step_count);
    end
    check("sstep step_count", 32'(step_count), 32'(en));
    check("sstep running",    32'(running),    32'd1);
    single_step = 1'b0;
    rst_n = 1'b0; tick; rst_n = 1'b1;
    check("midrst cur_state",  32'(cur_state),  32'd0);
    check("midrst head",       32'(head),       32'd0);
    check("midrst step_count", 32'(step_count), 32'd0);
    check("midrst running",    32'(running),    32'd0);
    check("midrst halted",     32'(halted),     32'd0);
    check("midrst fault",      32'(fault),      32'd0);
    check_tape("midrst");

    // Load/start collision in IDLE, then load attempt during RUN
    load_en = 1'b1; start = 1'b1; load_addr = 4'd4; load_sym = 3'd6;
    tick;
    load_en = 1'b0; start = 1'b0; m_tape[4] = 3'd6;
    check("collide running", 32'(running), 32'd0);
    tick;
    check("collide still idle", 32'(running), 32'd0);
    load_addr = 4'd4; #1;
    check("collide tape4", 32'(rd_sym), 32'd6);

    // Step limit with a never-halting ping-pong
    tf_mode = M_PING;
    run_and_check("limit", 3'd0, 4'd10, 1);
    check("limit step_count lit", 32'(step_count), 32'd5);
    load_addr = 4'd4; #1;
    check("run-load ignored tape4", 32'(rd_sym), 32'd6);

    // Random tapes, tables and start points
    tf_mode = M_RAND;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 64; i++) tf_tab[i] = 7'($urandom);
      for (int a = 0; a < TL; a++) load_cell(a, 3'($urandom_range(0, 7)));
      run_and_check($sformatf("rand%0d", it), 3'($urandom_range(0, 7)),
                    4'($urandom_range(0, TL - 1)), 0);
      check_tape($sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
